// File: rtl/fetcher_pkg.sv
`default_nettype none
// ============================================================================
// Module : fetcher_pkg
// Brief  : Shared types and constants for the instruction fetch stage.
//          Exception cause codes are also used by the trap/CSR logic.
// Rev    : 1.0  initial release
// ============================================================================
package fetcher_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fetch_state_t;

    localparam logic [3:0] FETCH_MISALIGNED   = 4'd0;
    localparam logic [3:0] FETCH_ACCESS_FAULT = 4'd1;

    // Word-aligned bus address for a byte pc.
    function automatic logic [31:0] word_addr(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetcher_if.sv
`default_nettype none
// ============================================================================
// Module : fetcher_if
// Brief  : Fetch-stage bundle: start/flush control, result towards the
//          decoder and the instruction memory request/ack bus.
//          slave  = fetch stage side, master = core/memory environment side.
// Rev    : 1.0  initial release
// ============================================================================
interface fetcher_if;
    logic        enabled;
    logic        flush;
    logic [31:0] pc;
    logic        completed;
    logic        busy;
    logic [31:0] instr_raw;
    logic [31:0] pc_out;
    logic        exc_valid;
    logic [3:0]  exc_cause;
    logic [31:0] exc_tval;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        mem_err;

    modport slave (
        input  enabled, flush, pc, mem_ack, mem_rdata, mem_err,
        output completed, busy, instr_raw, pc_out, exc_valid, exc_cause,
               exc_tval, mem_req, mem_addr
    );

    modport master (
        output enabled, flush, pc, mem_ack, mem_rdata, mem_err,
        input  completed, busy, instr_raw, pc_out, exc_valid, exc_cause,
               exc_tval, mem_req, mem_addr
    );
endinterface
`default_nettype wire

// File: rtl/fetcher.sv
`default_nettype none
// ============================================================================
// Module : fetcher
// Brief  : Multi-cycle instruction fetch. Reads one word per accepted start
//          pulse, reports misalignment, bus error and bus timeout as fetch
//          exceptions, and supports flushing an in-flight request.
// Rev    : 1.0  initial release
// ============================================================================
module fetcher
    import fetcher_pkg::*;
#(
    parameter int TIMEOUT = 1024
) (
    input  wire logic clk,
    input  wire logic rstn,
    fetcher_if.slave  bus
);

    localparam int CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    fetch_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      pc_lat_q, pc_lat_d;
    logic             completed_q, completed_d;
    logic             busy_q, busy_d;
    logic [31:0]      instr_q, instr_d;
    logic [31:0]      pc_out_q, pc_out_d;
    logic             exc_valid_q, exc_valid_d;
    logic [3:0]       exc_cause_q, exc_cause_d;
    logic [31:0]      exc_tval_q, exc_tval_d;
    logic             mem_req_q, mem_req_d;
    logic [31:0]      mem_addr_q, mem_addr_d;

    logic             timeout_hit;
    logic [CNT_W-1:0] cnt_inc;

    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);
    assign cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    // Next-state and registered-output computation for the fetch FSM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_lat_d    = pc_lat_q;
        completed_d = 1'b0;
        instr_d     = instr_q;
        pc_out_d    = pc_out_q;
        exc_valid_d = exc_valid_q;
        exc_cause_d = exc_cause_q;
        exc_tval_d  = exc_tval_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;

        case (state_q)
            IDLE: begin
                if (bus.enabled && !bus.flush) begin
                    if (bus.pc[1:0] != 2'b00) begin
                        state_d     = DONE;
                        completed_d = 1'b1;
                        instr_d     = '0;
                        pc_out_d    = bus.pc;
                        exc_valid_d = 1'b1;
                        exc_cause_d = FETCH_MISALIGNED;
                        exc_tval_d  = bus.pc;
                    end else begin
                        state_d    = WAIT;
                        mem_req_d  = 1'b1;
                        mem_addr_d = word_addr(bus.pc);
                        pc_lat_d   = bus.pc;
                        cnt_d      = '0;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_inc;
                if (bus.flush) begin
                    // An ack in the flush cycle is consumed; an expiring
                    // timeout also ends the access, otherwise wait it out.
                    if (bus.mem_ack || timeout_hit) begin
                        state_d   = IDLE;
                        mem_req_d = 1'b0;
                    end else begin
                        state_d = DRAIN;
                    end
                end else if (bus.mem_ack) begin
                    state_d     = DONE;
                    mem_req_d   = 1'b0;
                    completed_d = 1'b1;
                    pc_out_d    = pc_lat_q;
                    instr_d     = bus.mem_err ? 32'h0 : bus.mem_rdata;
                    exc_valid_d = bus.mem_err;
                    exc_cause_d = bus.mem_err ? FETCH_ACCESS_FAULT : 4'd0;
                    exc_tval_d  = bus.mem_err ? pc_lat_q : 32'h0;
                end else if (timeout_hit) begin
                    state_d     = DONE;
                    mem_req_d   = 1'b0;
                    completed_d = 1'b1;
                    pc_out_d    = pc_lat_q;
                    instr_d     = '0;
                    exc_valid_d = 1'b1;
                    exc_cause_d = FETCH_ACCESS_FAULT;
                    exc_tval_d  = pc_lat_q;
                end
            end
            DRAIN: begin
                cnt_d = cnt_inc;
                if (bus.mem_ack || timeout_hit) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pc_lat_q    <= '0;
            completed_q <= 1'b0;
            busy_q      <= 1'b0;
            instr_q     <= '0;
            pc_out_q    <= '0;
            exc_valid_q <= 1'b0;
            exc_cause_q <= '0;
            exc_tval_q  <= '0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pc_lat_q    <= pc_lat_d;
            completed_q <= completed_d;
            busy_q      <= busy_d;
            instr_q     <= instr_d;
            pc_out_q    <= pc_out_d;
            exc_valid_q <= exc_valid_d;
            exc_cause_q <= exc_cause_d;
            exc_tval_q  <= exc_tval_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
        end
    end

    // completed is only ever high in DONE; a flush in that cycle cancels the
    // hand-off to the decoder, so it masks the registered pulse.
    assign bus.completed = completed_q & ~bus.flush;
    assign bus.busy      = busy_q;
    assign bus.instr_raw = instr_q;
    assign bus.pc_out    = pc_out_q;
    assign bus.exc_valid = exc_valid_q;
    assign bus.exc_cause = exc_cause_q;
    assign bus.exc_tval  = exc_tval_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_addr  = mem_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_fetcher.sv
`default_nettype none
// ============================================================================
// Module : tb_fetcher
// Brief  : Self-checking bench for fetcher (TIMEOUT=8): directed table,
//          randomized transactions against a transaction-level model, and
//          hand-written reset / flush sequences.
// Rev    : 1.0  initial release
// ============================================================================
module tb_fetcher;

    localparam int TO = 8;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    fetcher_if bus();

    fetcher #(.TIMEOUT(TO)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // One fetch: stimulus plus expected cycle numbers (relative to the
    // cycle in which enabled is driven) and expected result.
    typedef struct {
        logic [31:0] pc;
        int          lat;       // cycle of mem_ack, 0 = never
        logic        err;
        logic [31:0] rdata;
        int          flush_at;  // cycle of flush, 0 = none
        int          stray_en;  // cycle of an enable while busy, 0 = none
        int          exp_req;   // mem_req high in cycles 1..exp_req
        int          exp_busy;  // busy high in cycles 1..exp_busy
        int          exp_cmpl;  // completed cycle, 0 = none
        logic [31:0] exp_instr;
        logic        exp_exc;
        logic [3:0]  exp_cause;
        logic [31:0] exp_tval;
    } txn_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp_v);
        end
    endtask

    function automatic txn_t mk(input logic [31:0] pc, input int lat, input logic err,
                                input logic [31:0] rdata, input int flush_at, input int stray,
                                input int req, input int busy, input int cmpl,
                                input logic [31:0] instr, input logic exc,
                                input logic [3:0] cause, input logic [31:0] tval);
        txn_t t;
        t.pc = pc; t.lat = lat; t.err = err; t.rdata = rdata;
        t.flush_at = flush_at; t.stray_en = stray;
        t.exp_req = req; t.exp_busy = busy; t.exp_cmpl = cmpl;
        t.exp_instr = instr; t.exp_exc = exc; t.exp_cause = cause; t.exp_tval = tval;
        return t;
    endfunction

    // Transaction-level reference: when does the access end, does it
    // complete, and with what result.
    function automatic txn_t model(input txn_t t);
        txn_t r = t;
        int   done_at;
        r.exp_instr = 0; r.exp_exc = 0; r.exp_cause = 0; r.exp_tval = 0;
        if (t.pc % 4 != 0) begin
            r.exp_req  = 0;
            r.exp_busy = 1;
            done_at    = 1;
            r.exp_exc  = 1; r.exp_cause = 0; r.exp_tval = t.pc;
        end else begin
            r.exp_req = (t.lat != 0) ? t.lat : TO;
            if (t.flush_at != 0 && t.flush_at <= r.exp_req) begin
                r.exp_busy = r.exp_req;
                r.exp_cmpl = 0;
                return r;
            end
            r.exp_busy = r.exp_req + 1;
            done_at    = r.exp_req + 1;
            if (t.lat != 0 && !t.err) r.exp_instr = t.rdata;
            else begin
                r.exp_exc = 1; r.exp_cause = 1; r.exp_tval = t.pc;
            end
        end
        r.exp_cmpl = (t.flush_at == done_at) ? 0 : done_at;
        return r;
    endfunction

    task automatic run_txn(input txn_t t);
        int last;
        last = t.exp_busy + 1;
        for (int c = 0; c <= last; c++) begin
            @(posedge clk); #1;
            bus.enabled   = (c == 0) || (t.stray_en != 0 && c == t.stray_en);
            bus.pc        = (c == 0) ? t.pc : $urandom();
            bus.flush     = (t.flush_at != 0 && c == t.flush_at);
            bus.mem_ack   = (t.lat != 0 && c == t.lat);
            bus.mem_err   = bus.mem_ack ? t.err : 1'($urandom_range(0, 1));
            bus.mem_rdata = bus.mem_ack ? t.rdata : $urandom();
            @(negedge clk);
            chk("busy", 32'(bus.busy), 32'(c >= 1 && c <= t.exp_busy));
            chk("mem_req", 32'(bus.mem_req), 32'(c >= 1 && c <= t.exp_req));
            if (c >= 1 && c <= t.exp_req)
                chk("mem_addr", bus.mem_addr, {t.pc[31:2], 2'b00});
            chk("completed", 32'(bus.completed), 32'(t.exp_cmpl != 0 && c == t.exp_cmpl));
            if (t.exp_cmpl != 0 && c == t.exp_cmpl) begin
                chk("instr_raw", bus.instr_raw, t.exp_instr);
                chk("pc_out", bus.pc_out, t.pc);
                chk("exc_valid", 32'(bus.exc_valid), 32'(t.exp_exc));
                chk("exc_cause", 32'(bus.exc_cause), 32'(t.exp_cause));
                chk("exc_tval", bus.exc_tval, t.exp_tval);
            end
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_completed"}, 32'(bus.completed), 32'h0);
        chk({tag, "_busy"},      32'(bus.busy),      32'h0);
        chk({tag, "_mem_req"},   32'(bus.mem_req),   32'h0);
        chk({tag, "_mem_addr"},  bus.mem_addr,       32'h0);
        chk({tag, "_instr_raw"}, bus.instr_raw,      32'h0);
        chk({tag, "_pc_out"},    bus.pc_out,         32'h0);
        chk({tag, "_exc_valid"}, 32'(bus.exc_valid), 32'h0);
        chk({tag, "_exc_cause"}, 32'(bus.exc_cause), 32'h0);
        chk({tag, "_exc_tval"},  bus.exc_tval,       32'h0);
    endtask

    txn_t tbl[11];

    initial begin
        txn_t t;

        tbl[0]  = mk(32'h100, 4, 0, 32'h00A00093, 0, 2, 4, 5, 5, 32'h00A00093, 0, 0, 0);
        tbl[1]  = mk(32'h102, 0, 0, 32'h0,        0, 0, 0, 1, 1, 32'h0, 1, 0, 32'h102);
        tbl[2]  = mk(32'h200, 2, 1, 32'hDEADBEEF, 0, 0, 2, 3, 3, 32'h0, 1, 1, 32'h200);
        tbl[3]  = mk(32'h300, 0, 0, 32'h0,        0, 0, 8, 9, 9, 32'h0, 1, 1, 32'h300);
        tbl[4]  = mk(32'h400, 5, 0, 32'h11111111, 3, 0, 5, 5, 0, 32'h0, 0, 0, 0);
        tbl[5]  = mk(32'h104, 1, 0, 32'h12345678, 0, 0, 1, 2, 2, 32'h12345678, 0, 0, 0);
        tbl[6]  = mk(32'h108, 2, 0, 32'hCAFEF00D, 3, 0, 2, 3, 0, 32'h0, 0, 0, 0);
        tbl[7]  = mk(32'h10B, 0, 0, 32'h0,        1, 0, 0, 1, 0, 32'h0, 0, 0, 0);
        tbl[8]  = mk(32'h10C, 3, 0, 32'hAAAA5555, 3, 0, 3, 3, 0, 32'h0, 0, 0, 0);
        tbl[9]  = mk(32'h110, 0, 0, 32'h0,        4, 0, 8, 8, 0, 32'h0, 0, 0, 0);
        tbl[10] = mk(32'h114, 8, 0, 32'h0BADC0DE, 0, 0, 8, 9, 9, 32'h0BADC0DE, 0, 0, 0);

        bus.enabled = 0; bus.flush = 0; bus.pc = 0;
        bus.mem_ack = 0; bus.mem_rdata = 0; bus.mem_err = 0;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk); #1;
        rstn = 1'b1;

        // Directed table.
        for (int i = 0; i < 11; i++) run_txn(tbl[i]);

        // enabled together with flush is not accepted.
        @(posedge clk); #1;
        bus.enabled = 1; bus.flush = 1; bus.pc = 32'h120;
        @(posedge clk); #1;
        bus.enabled = 0; bus.flush = 0;
        @(negedge clk);
        chk("enflush_busy", 32'(bus.busy), 32'h0);
        chk("enflush_req", 32'(bus.mem_req), 32'h0);

        // Reset while waiting on the bus, then a stale ack in IDLE.
        @(posedge clk); #1;
        bus.enabled = 1; bus.pc = 32'h500;
        @(posedge clk); #1;
        bus.enabled = 0;
        @(posedge clk); #1;
        rstn = 1'b0;
        @(negedge clk);
        chk("prerst_req", 32'(bus.mem_req), 32'h1);
        @(posedge clk); #1;
        rstn = 1'b1;
        bus.mem_ack = 1; bus.mem_rdata = 32'h55AA55AA; bus.mem_err = 0;
        @(negedge clk);
        chk_all_zero("midrst");
        @(posedge clk); #1;
        bus.mem_ack = 0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("stale_completed", 32'(bus.completed), 32'h0);
            chk("stale_busy", 32'(bus.busy), 32'h0);
            chk("stale_req", 32'(bus.mem_req), 32'h0);
            @(posedge clk); #1;
        end

        // Randomized transactions against the reference model.
        for (int n = 0; n < 150; n++) begin
            t.pc = $urandom();
            if ($urandom_range(0, 3) != 0) t.pc[1:0] = 2'b00;
            t.lat      = (t.pc[1:0] == 2'b00) ? int'($urandom_range(0, TO)) : 0;
            t.err      = ($urandom_range(0, 3) == 0);
            t.rdata    = $urandom();
            t.flush_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 10)) : 0;
            t.stray_en = 0;
            t = model(t);
            if ($urandom_range(0, 2) == 0) t.stray_en = int'($urandom_range(1, t.exp_busy));
            run_txn(t);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
